note_fetch_ctrl: RTL

NOTE_FETCH_CTRL -- requirements
Module: note_fetch_ctrl

---
 rtl/music_pkg.sv | 23 ++
 rtl/score_rom.sv | 39 +++
 rtl/note_fetch_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/music_pkg.sv
// music_pkg: shared definitions for the score player.
//   CODE_W   note-code width (0 = rest, 1..24 = C4..B5)
//   REST     the rest code
//   state_t  fetch/playback controller states
//   code_hz  note code to tone frequency in Hz (0 = silence)
// No ports.
package music_pkg;
  localparam int CODE_W = 5;
  localparam logic [CODE_W-1:0] REST = '0;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SOUND, GAP} state_t;
  // Indexed by the full code range, so codes 25..31 fall on silent entries.
  localparam logic [15:0] NOTE_HZ [32] = '{
    16'd0,
    16'd262, 16'd277, 16'd294, 16'd311, 16'd330, 16'd349,
    16'd370, 16'd392, 16'd415, 16'd440, 16'd466, 16'd494,
    16'd523, 16'd554, 16'd587, 16'd622, 16'd659, 16'd698,
    16'd740, 16'd784, 16'd831, 16'd880, 16'd932, 16'd988,
    16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0
  };
  function automatic logic [15:0] code_hz(input logic [CODE_W-1:0] code);
    return NOTE_HZ[code];
  endfunction
endpackage

// File: rtl/score_rom.sv
// score_rom: 4096 x 6 score memory, word = {tie, code}, synchronous read.
//   clk   read clock
//   en    read enable; data holds its last word while low
//   addr  beat index
//   data  registered word, valid one cycle after an enabled read
module score_rom
  import music_pkg::*;
(
  input  logic              clk,
  input  logic              en,
  input  logic [11:0]       addr,
  output logic [CODE_W:0]   data
);
  // The first sixteen beats hold a hand-written phrase with repeats and ties;
  // the rest of the score is a fixed scramble of the address.
  function automatic logic [CODE_W:0] score_word(input logic [11:0] a);
    case (a)
      12'd0:   return {1'b0, 5'd0};
      12'd1:   return {1'b0, 5'd1};
      12'd2:   return {1'b0, 5'd1};
      12'd3:   return {1'b1, 5'd1};
      12'd4:   return {1'b0, 5'd5};
      12'd5:   return {1'b0, 5'd5};
      12'd6:   return {1'b1, 5'd5};
      12'd7:   return {1'b0, 5'd24};
      12'd8:   return {1'b0, 5'd25};
      12'd9:   return {1'b0, 5'd12};
      12'd10:  return {1'b0, 5'd3};
      12'd11:  return {1'b0, 5'd7};
      12'd12:  return {1'b0, 5'd12};
      12'd13:  return {1'b1, 5'd12};
      12'd14:  return {1'b0, 5'd0};
      12'd15:  return {1'b1, 5'd0};
      default: return {a[10], a[4:0] ^ a[9:5]};
    endcase
  endfunction
  always_ff @(posedge clk)
    if (en) data <= score_word(addr);
endmodule

// File: rtl/note_fetch_ctrl.sv
// note_fetch_ctrl: turns beat indices into note codes and tone frequencies.
//   clk         clock
//   reset       asynchronous active-high reset
//   ibeat       beat index from the player controller
//   play_pause  1 = play, 0 = pause
//   note_code   current note (0 = rest)
//   freq        tone frequency in Hz (0 = silence)
//   note_on     one-cycle pulse when a new note starts sounding
// Build option NOTE_GAP_EN: repeated untied notes get a silent articulation
// gap of GAP_CYCLES cycles; ties sustain. Without it every non-rest note pulses.
module note_fetch_ctrl
  import music_pkg::*;
#(
  parameter int LEN        = 4095,
  parameter int GAP_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [11:0]       ibeat,
  input  logic              play_pause,
  output logic [CODE_W-1:0] note_code,
  output logic [15:0]       freq,
  output logic              note_on
);
  state_t state, state_n;
  logic [11:0] last_ibeat;
  logic [CODE_W:0] rom_q;
  logic [CODE_W-1:0] new_code;
  logic play_q, pulse_q, change, resume, in_range, load_ok, sustain, gap_hit, gap_done;
  assign change   = ibeat != last_ibeat;
  assign resume   = play_pause & ~play_q;
  // last_ibeat is stable through FETCH/LOAD unless a newer beat aborts them.
  assign in_range = 32'(last_ibeat) < LEN;
  assign new_code = in_range ? rom_q[CODE_W-1:0] : REST;
  assign load_ok  = play_pause & ~change & (state == LOAD);
  score_rom u_rom (
    .clk  (clk),
    .en   ((state == FETCH) & in_range),
    .addr (last_ibeat),
    .data (rom_q)
  );
`ifdef NOTE_GAP_EN
  logic [CODE_W-1:0] prev_code;
  logic [19:0] gap_cnt;
  logic tie;
  assign tie      = in_range & rom_q[CODE_W];
  assign sustain  = tie & (new_code == prev_code);
  assign gap_hit  = ~tie & (new_code != REST) & (new_code == prev_code);
  assign gap_done = gap_cnt >= 20'(GAP_CYCLES - 1);
  // prev_code is forgotten on pause so a resumed note always restarts cleanly.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      prev_code <= REST;
      gap_cnt   <= '0;
    end else begin
      if (!play_pause) prev_code <= REST;
      else if (load_ok) prev_code <= new_code;
      if (load_ok) gap_cnt <= '0;
      else if (state == GAP && gap_cnt != '1) gap_cnt <= gap_cnt + 20'd1;
    end
`else
  logic unused_tie;
  localparam int unused_gap = GAP_CYCLES;
  assign unused_tie = rom_q[CODE_W];
  assign sustain    = 1'b0;
  assign gap_hit    = 1'b0;
  assign gap_done   = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // The newest beat always restarts the fetch, whatever was in flight.
  always_comb begin
    state_n = state;
    if (!play_pause) state_n = IDLE;
    else if (change) state_n = FETCH;
    else
      case (state)
        IDLE:    state_n = resume ? FETCH : IDLE;
        FETCH:   state_n = LOAD;
        LOAD:    state_n = gap_hit ? GAP : SOUND;
        GAP:     state_n = gap_done ? SOUND : GAP;
        default: state_n = SOUND;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      last_ibeat <= '0;
      play_q     <= 1'b0;
      note_code  <= REST;
      pulse_q    <= 1'b0;
    end else begin
      last_ibeat <= ibeat;
      play_q     <= play_pause;
      if (load_ok) note_code <= new_code;
      pulse_q    <= play_pause & (state_n == SOUND) &
                    ((load_ok & (new_code != REST) & ~sustain) | (state == GAP));
    end
  always_comb begin
    freq    = (play_pause && state != IDLE && state != GAP) ? code_hz(note_code) : 16'd0;
    note_on = pulse_q & play_pause;
  end
endmodule
